rollback_multi_handler: RTL and testbench
=========================================

Name: rollback_multi_handler

Overview:
- Parametrised successor of the core's rollback stage. Sits between the Branch Control, Instruction Scheduler and Control Register.
- Restores per-thread PCs and generates per-thread scoreboard clear bitmaps on branch rollback.
- Accepts N_TRAP_SRC trap sources (LDST, SPM, FPU, …) instead of a fixed two, and uses a configurable flush window.
- Trap reports to the Control Register are serialised through per-source pending slots, so simultaneous traps are never lost silently.

Parameters:
- N_THREADS, 8, hardware thread count; TID_W = $clog2(N_THREADS), min 1
- SB_LEN, 64, scoreboard length in bits
- ADDR_W, 32, PC width
- REG_W, 32, trap-reason width
- N_TRAP_SRC, 2, number of trap rollback sources; index 0 = highest priority
- FLUSH_DEPTH, 4, cycles an issued instruction stays flushable; range 1..8

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  stage enable; when low all state holds
- is_instruction_valid  in  1  scheduler issued an instruction this cycle
- is_thread_id  in  TID_W  issuing thread
- is_destination_mask  in  SB_LEN  scoreboard bits set by the issue
- bc_rollback_enable  in  1  branch requests PC restore
- bc_rollback_valid  in  1  branch requests scoreboard flush
- bc_rollback_pc  in  ADDR_W  restore PC
- bc_rollback_thread_id  in  TID_W  branching thread
- bc_scoreboard  in  SB_LEN  bits to flush for the branching thread
- trap_en  in  N_TRAP_SRC  per-source trap request
- trap_pc  in  N_TRAP_SRC*ADDR_W  per-source restore PC
- trap_thread_id  in  N_TRAP_SRC*TID_W  per-source thread
- trap_reason  in  N_TRAP_SRC*REG_W  per-source reason code
- rollback_valid  out  N_THREADS  combinational per-thread rollback
- rollback_pc_value  out  N_THREADS*ADDR_W  combinational per-thread PC; 0 when not valid
- rollback_clear_bitmap  out  N_THREADS*SB_LEN  combinational next-value clear bitmap
- rollback_trap_en  out  1  registered trap report strobe
- rollback_thread_id  out  TID_W  registered trap thread
- rollback_trap_reason  out  REG_W  registered trap reason
- trap_drop  out  N_TRAP_SRC  sticky per-source overflow flag
- rollback_count  out  N_THREADS*16  per-thread rollback counters (optional feature)

Behaviour:
- Reset values: clear bitmaps, issue-age shift registers, pending slots, trap_drop, counters, rollback_trap_en, rollback_thread_id and rollback_trap_reason are all 0.
- Rollback select (combinational), per thread t, priority order:
  - bc_rollback_enable with bc thread == t → bc_rollback_pc
  - else the lowest-index source s with trap_en[s] and trap_thread_id[s] == t → trap_pc[s]
  - else rollback_valid[t] = 0 and PC = 0
  - Different threads may roll back in the same cycle.
- Issue tracking, per thread: shift register age[0..FLUSH_DEPTH-1] of SB_LEN.
  - age[0] <= this cycle's issue mask for t.
  - age[k] <= age[k-1].
  - age[FLUSH_DEPTH-1] is the mask that has aged out.
- Clear bitmap next value: next = (bitmap & ~aged_out & ~flush) | issue, where:
  - flush = bc_scoreboard only when bc_rollback_valid and the bc thread == t; it never touches other threads.
  - issue = is_destination_mask when is_instruction_valid and is_thread_id == t.
  - rollback_clear_bitmap[t] = next, in the same cycle.
- On rollback_valid[t] with enable high: the bitmap and all age stages of t are zeroed on the next edge, overriding next.
- Trap arbitration:
  - A new trap_en[s] fills pending slot s, capturing tid and reason.
  - Each enabled cycle the lowest-index source that is pending or newly requesting is reported on the next edge. Its slot is freed and rollback_trap_en = 1 for one cycle.
  - A new request that wins directly bypasses its slot, giving 1-cycle latency.
- Overflow: trap_en[s] while slot s is occupied and not draining this cycle → the new request is discarded (the older one is kept) and trap_drop[s] is set sticky until reset.
- When no trap is reported: rollback_trap_en = 0; rollback_thread_id and rollback_trap_reason are 0.
- enable low: registers hold; combinational outputs stay valid; traps arriving while enable is low are not captured.
- Reset asserted mid-operation discards pending traps and age history immediately.

Optional Feature:
- ROLLBACK_PERF_CNT_EN defined: per-thread 16-bit saturating counter, incremented on each enabled cycle with rollback_valid[t]; holds at 0xFFFF.
- Not defined: rollback_count tied to 0 and no counter flops are built.

Decomposition:
- Package rollback_pkg: trap_req_t {valid, tid, pc, reason}, the TID_W function, the counter width constant, and the LDST/SPM reason codes.
- Sub-module rollback_issue_tracker, one per thread: owns the age shift register and the clear bitmap; inputs issue mask, flush mask and rollback; output next bitmap.

Test Plan:
1. FLUSH_DEPTH=4: issue thread 2 mask 0x10 at cycle 0, nothing else → bitmap bit4 is set for cycles 0–3 and clears at cycle 4.
2. Issue thread 1 mask 0x3 at cycle 0; bc_rollback_valid with thread 1, bc_scoreboard 0x1 at cycle 2 → next bitmap 0x2; thread 0 bitmap unchanged.
3. bc_rollback_enable thread 3, PC 0x400, and trap_en[0] thread 3, PC 0x800 in the same cycle → rollback_pc_value[3] = 0x400; the trap is still reported next cycle.
4. trap_en = 2'b11, threads 1 and 5, reasons A and B → cycle+1: tid 1 / A; cycle+2: tid 5 / B; rollback_trap_en high for both cycles.
5. Source 1 requests three cycles in a row while source 0 also requests → third source-1 request dropped, trap_drop[1] = 1.
6. ROLLBACK_PERF_CNT_EN: force 0x10000 rollbacks on thread 0 → rollback_count[0] = 0xFFFF.

Source files
------------

// File: rtl/rollback_pkg.sv
// Shared types and constants for the rollback stage: trap request record,
// thread-id width helper, perf-counter width and trap reason codes.
package rollback_pkg;

  localparam int CNT_W      = 16;
  localparam int DEF_TID_W  = 3;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_REG_W  = 32;

  localparam logic [DEF_REG_W-1:0] REASON_LDST = 32'h0000_0001;
  localparam logic [DEF_REG_W-1:0] REASON_SPM  = 32'h0000_0002;

  typedef struct packed {
    logic                  valid;
    logic [DEF_TID_W-1:0]  tid;
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_REG_W-1:0]  reason;
  } trap_req_t;

  function automatic int tid_width(input int n_threads);
    return (n_threads <= 2) ? 1 : $clog2(n_threads);
  endfunction

endpackage

// File: rtl/rollback_issue_tracker.sv
// Per-thread issue age shift register and scoreboard clear bitmap.
// next_bitmap is the combinational value the bitmap takes on the next edge.
module rollback_issue_tracker #(
  parameter int SB_LEN      = 64,
  parameter int FLUSH_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              rollback,
  input  logic [SB_LEN-1:0] issue,
  input  logic [SB_LEN-1:0] flush,
  output logic [SB_LEN-1:0] next_bitmap
);

  logic [SB_LEN-1:0] bitmap;
  logic [SB_LEN-1:0] age [FLUSH_DEPTH];

  // The last age stage holds the mask that is no longer flushable.
  assign next_bitmap = (bitmap & ~age[FLUSH_DEPTH-1] & ~flush) | issue;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bitmap <= '0;
      for (int k = 0; k < FLUSH_DEPTH; k++) age[k] <= '0;
    end else if (enable) begin
      if (rollback) begin
        bitmap <= '0;
        for (int k = 0; k < FLUSH_DEPTH; k++) age[k] <= '0;
      end else begin
        bitmap <= next_bitmap;
        age[0] <= issue;
        for (int k = 1; k < FLUSH_DEPTH; k++) age[k] <= age[k-1];
      end
    end
  end

endmodule

// File: rtl/rollback_multi_handler.sv
// Rollback stage: per-thread PC restore, scoreboard clear bitmaps and
// serialised trap reporting. Optional counters: ROLLBACK_PERF_CNT_EN.
module rollback_multi_handler
  import rollback_pkg::*;
#(
  parameter int N_THREADS   = 8,
  parameter int SB_LEN      = 64,
  parameter int ADDR_W      = 32,
  parameter int REG_W       = 32,
  parameter int N_TRAP_SRC  = 2,
  parameter int FLUSH_DEPTH = 4,
  localparam int TID_W      = tid_width(N_THREADS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         is_instruction_valid,
  input  logic [TID_W-1:0]             is_thread_id,
  input  logic [SB_LEN-1:0]            is_destination_mask,
  input  logic                         bc_rollback_enable,
  input  logic                         bc_rollback_valid,
  input  logic [ADDR_W-1:0]            bc_rollback_pc,
  input  logic [TID_W-1:0]             bc_rollback_thread_id,
  input  logic [SB_LEN-1:0]            bc_scoreboard,
  input  logic [N_TRAP_SRC-1:0]        trap_en,
  input  logic [N_TRAP_SRC*ADDR_W-1:0] trap_pc,
  input  logic [N_TRAP_SRC*TID_W-1:0]  trap_thread_id,
  input  logic [N_TRAP_SRC*REG_W-1:0]  trap_reason,
  output logic [N_THREADS-1:0]         rollback_valid,
  output logic [N_THREADS*ADDR_W-1:0]  rollback_pc_value,
  output logic [N_THREADS*SB_LEN-1:0]  rollback_clear_bitmap,
  output logic                         rollback_trap_en,
  output logic [TID_W-1:0]             rollback_thread_id,
  output logic [REG_W-1:0]             rollback_trap_reason,
  output logic [N_TRAP_SRC-1:0]        trap_drop,
  output logic [N_THREADS*CNT_W-1:0]   rollback_count
);

  // Branch wins over traps; among traps the lowest source index wins.
  always_comb begin
    rollback_valid    = '0;
    rollback_pc_value = '0;
    for (int t = 0; t < N_THREADS; t++) begin
      if (bc_rollback_enable && bc_rollback_thread_id == TID_W'(t)) begin
        rollback_valid[t] = 1'b1;
        rollback_pc_value[t*ADDR_W +: ADDR_W] = bc_rollback_pc;
      end else begin
        for (int s = N_TRAP_SRC - 1; s >= 0; s--) begin
          if (trap_en[s] && trap_thread_id[s*TID_W +: TID_W] == TID_W'(t)) begin
            rollback_valid[t] = 1'b1;
            rollback_pc_value[t*ADDR_W +: ADDR_W] = trap_pc[s*ADDR_W +: ADDR_W];
          end
        end
      end
    end
  end

  for (genvar t = 0; t < N_THREADS; t++) begin : g_thread
    logic [SB_LEN-1:0] issue;
    logic [SB_LEN-1:0] flush;

    assign issue = (is_instruction_valid && is_thread_id == TID_W'(t)) ? is_destination_mask : '0;
    assign flush = (bc_rollback_valid && bc_rollback_thread_id == TID_W'(t)) ? bc_scoreboard : '0;

    rollback_issue_tracker #(
      .SB_LEN      (SB_LEN),
      .FLUSH_DEPTH (FLUSH_DEPTH)
    ) u_tracker (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .rollback    (rollback_valid[t]),
      .issue       (issue),
      .flush       (flush),
      .next_bitmap (rollback_clear_bitmap[t*SB_LEN +: SB_LEN])
    );
  end

  logic [N_TRAP_SRC-1:0] pend_v;
  logic [TID_W-1:0]      pend_tid    [N_TRAP_SRC];
  logic [REG_W-1:0]      pend_reason [N_TRAP_SRC];
  logic [N_TRAP_SRC-1:0] win_sel;
  logic                  win_found;
  logic [TID_W-1:0]      win_tid;
  logic [REG_W-1:0]      win_reason;

  // A pending slot always holds the older request, so it is reported first.
  always_comb begin
    win_sel    = '0;
    win_found  = 1'b0;
    win_tid    = '0;
    win_reason = '0;
    for (int s = 0; s < N_TRAP_SRC; s++) begin
      if (!win_found && (pend_v[s] || trap_en[s])) begin
        win_found  = 1'b1;
        win_sel[s] = 1'b1;
        win_tid    = pend_v[s] ? pend_tid[s] : trap_thread_id[s*TID_W +: TID_W];
        win_reason = pend_v[s] ? pend_reason[s] : trap_reason[s*REG_W +: REG_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rollback_trap_en     <= 1'b0;
      rollback_thread_id   <= '0;
      rollback_trap_reason <= '0;
      pend_v               <= '0;
      trap_drop            <= '0;
      for (int s = 0; s < N_TRAP_SRC; s++) begin
        pend_tid[s]    <= '0;
        pend_reason[s] <= '0;
      end
    end else if (enable) begin
      rollback_trap_en     <= win_found;
      rollback_thread_id   <= win_tid;
      rollback_trap_reason <= win_reason;
      for (int s = 0; s < N_TRAP_SRC; s++) begin
        if (trap_en[s]) begin
          if (pend_v[s] && !win_sel[s]) begin
            trap_drop[s] <= 1'b1;
          end else if (pend_v[s] || !win_sel[s]) begin
            pend_v[s]      <= 1'b1;
            pend_tid[s]    <= trap_thread_id[s*TID_W +: TID_W];
            pend_reason[s] <= trap_reason[s*REG_W +: REG_W];
          end
        end else if (win_sel[s]) begin
          pend_v[s] <= 1'b0;
        end
      end
    end
  end

`ifdef ROLLBACK_PERF_CNT_EN
  logic [CNT_W-1:0] cnt [N_THREADS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < N_THREADS; t++) cnt[t] <= '0;
    end else if (enable) begin
      for (int t = 0; t < N_THREADS; t++)
        if (rollback_valid[t] && cnt[t] != {CNT_W{1'b1}}) cnt[t] <= cnt[t] + 1'b1;
    end
  end

  for (genvar t = 0; t < N_THREADS; t++) begin : g_cnt
    assign rollback_count[t*CNT_W +: CNT_W] = cnt[t];
  end
`else
  assign rollback_count = '0;
`endif

endmodule

// File: tb/tb_rollback_multi_handler.sv
// Self-checking bench for rollback_multi_handler (default parameters);
// covers ROLLBACK_PERF_CNT_EN when the macro is defined.
module tb_rollback_multi_handler;
  import rollback_pkg::*;

  localparam int NT = 8;
  localparam int SB = 64;
  localparam int AW = 32;
  localparam int RW = 32;
  localparam int NS = 2;
  localparam int FD = 4;
  localparam int TW = 3;
  localparam int EXP_W = 1 + TW + RW + NS;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              is_instruction_valid;
  logic [TW-1:0]     is_thread_id;
  logic [SB-1:0]     is_destination_mask;
  logic              bc_rollback_enable;
  logic              bc_rollback_valid;
  logic [AW-1:0]     bc_rollback_pc;
  logic [TW-1:0]     bc_rollback_thread_id;
  logic [SB-1:0]     bc_scoreboard;
  logic [NS-1:0]     trap_en;
  logic [NS*AW-1:0]  trap_pc;
  logic [NS*TW-1:0]  trap_thread_id;
  logic [NS*RW-1:0]  trap_reason;
  logic [NT-1:0]     rollback_valid;
  logic [NT*AW-1:0]  rollback_pc_value;
  logic [NT*SB-1:0]  rollback_clear_bitmap;
  logic              rollback_trap_en;
  logic [TW-1:0]     rollback_thread_id;
  logic [RW-1:0]     rollback_trap_reason;
  logic [NS-1:0]     trap_drop;
  logic [NT*16-1:0]  rollback_count;

  rollback_multi_handler #(
    .N_THREADS(NT), .SB_LEN(SB), .ADDR_W(AW), .REG_W(RW), .N_TRAP_SRC(NS), .FLUSH_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .is_instruction_valid(is_instruction_valid), .is_thread_id(is_thread_id),
    .is_destination_mask(is_destination_mask),
    .bc_rollback_enable(bc_rollback_enable), .bc_rollback_valid(bc_rollback_valid),
    .bc_rollback_pc(bc_rollback_pc), .bc_rollback_thread_id(bc_rollback_thread_id),
    .bc_scoreboard(bc_scoreboard),
    .trap_en(trap_en), .trap_pc(trap_pc), .trap_thread_id(trap_thread_id), .trap_reason(trap_reason),
    .rollback_valid(rollback_valid), .rollback_pc_value(rollback_pc_value),
    .rollback_clear_bitmap(rollback_clear_bitmap),
    .rollback_trap_en(rollback_trap_en), .rollback_thread_id(rollback_thread_id),
    .rollback_trap_reason(rollback_trap_reason), .trap_drop(trap_drop),
    .rollback_count(rollback_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [EXP_W-1:0] exp_q[$];

  // reference model state
  logic [SB-1:0] m_bitmap [NT];
  logic [SB-1:0] m_age    [NT][FD];
  logic [15:0]   m_cnt    [NT];
  logic [NS-1:0] m_pv;
  logic [TW-1:0] m_ptid    [NS];
  logic [RW-1:0] m_preason [NS];
  logic [NS-1:0] m_drop;
  logic          m_out_en;
  logic [TW-1:0] m_out_tid;
  logic [RW-1:0] m_out_reason;

  trap_req_t req [NS];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < NT; t++) begin
      m_bitmap[t] = '0;
      m_cnt[t] = '0;
      for (int k = 0; k < FD; k++) m_age[t][k] = '0;
    end
    for (int s = 0; s < NS; s++) begin
      m_ptid[s] = '0;
      m_preason[s] = '0;
    end
    m_pv = '0; m_drop = '0;
    m_out_en = 1'b0; m_out_tid = '0; m_out_reason = '0;
  endtask

  // driver tasks
  task automatic drive_reqs();
    for (int s = 0; s < NS; s++) begin
      trap_en[s] = req[s].valid;
      trap_thread_id[s*TW +: TW] = req[s].tid;
      trap_pc[s*AW +: AW] = req[s].pc;
      trap_reason[s*RW +: RW] = req[s].reason;
    end
  endtask

  task automatic clear_inputs();
    enable = 1'b1;
    is_instruction_valid = 1'b0; is_thread_id = '0; is_destination_mask = '0;
    bc_rollback_enable = 1'b0; bc_rollback_valid = 1'b0; bc_rollback_pc = '0;
    bc_rollback_thread_id = '0; bc_scoreboard = '0;
    for (int s = 0; s < NS; s++) req[s] = '0;
    drive_reqs();
  endtask

  task automatic set_req(input int s, input logic [TW-1:0] tid, input logic [AW-1:0] pc,
                         input logic [RW-1:0] reason);
    req[s].valid = 1'b1; req[s].tid = tid; req[s].pc = pc; req[s].reason = reason;
    drive_reqs();
  endtask

  // One clock: check combinational outputs against the model, advance the
  // model, push the expected registered outputs and compare after the edge.
  task automatic step();
    logic          rv  [NT];
    logic [SB-1:0] nxt [NT];
    logic [SB-1:0] iss [NT];
    logic [EXP_W-1:0] e;
    logic          found;
    int            w;
    @(negedge clk);
    for (int t = 0; t < NT; t++) begin
      logic [AW-1:0] pc;
      logic [SB-1:0] fl;
      rv[t] = 1'b0; pc = '0; found = 1'b0;
      if (bc_rollback_enable && bc_rollback_thread_id == TW'(t)) begin
        rv[t] = 1'b1; pc = bc_rollback_pc;
      end else begin
        for (int s = 0; s < NS; s++)
          if (!found && trap_en[s] && trap_thread_id[s*TW +: TW] == TW'(t)) begin
            found = 1'b1; rv[t] = 1'b1; pc = trap_pc[s*AW +: AW];
          end
      end
      iss[t] = (is_instruction_valid && is_thread_id == TW'(t)) ? is_destination_mask : '0;
      fl = (bc_rollback_valid && bc_rollback_thread_id == TW'(t)) ? bc_scoreboard : '0;
      nxt[t] = (m_bitmap[t] & ~m_age[t][FD-1] & ~fl) | iss[t];
      check_val($sformatf("rv_t%0d", t), 64'(rollback_valid[t]), 64'(rv[t]));
      check_val($sformatf("pc_t%0d", t), 64'(rollback_pc_value[t*AW +: AW]), 64'(pc));
      check_val($sformatf("bitmap_t%0d", t), rollback_clear_bitmap[t*SB +: SB], nxt[t]);
      check_val($sformatf("count_t%0d", t), 64'(rollback_count[t*16 +: 16]), 64'(m_cnt[t]));
    end
    if (enable) begin
      for (int t = 0; t < NT; t++) begin
        if (rv[t]) begin
          m_bitmap[t] = '0;
          for (int k = 0; k < FD; k++) m_age[t][k] = '0;
        end else begin
          m_bitmap[t] = nxt[t];
          for (int k = FD - 1; k > 0; k--) m_age[t][k] = m_age[t][k-1];
          m_age[t][0] = iss[t];
        end
`ifdef ROLLBACK_PERF_CNT_EN
        if (rv[t] && m_cnt[t] != 16'hFFFF) m_cnt[t] = m_cnt[t] + 16'd1;
`endif
      end
      w = -1;
      for (int s = NS - 1; s >= 0; s--) if (m_pv[s] || trap_en[s]) w = s;
      m_out_en = (w >= 0); m_out_tid = '0; m_out_reason = '0;
      if (w >= 0) begin
        m_out_tid    = m_pv[w] ? m_ptid[w] : trap_thread_id[w*TW +: TW];
        m_out_reason = m_pv[w] ? m_preason[w] : trap_reason[w*RW +: RW];
      end
      for (int s = 0; s < NS; s++) begin
        if (s == w && !trap_en[s]) m_pv[s] = 1'b0;
        else if (trap_en[s] && m_pv[s] && s != w) m_drop[s] = 1'b1;
        else if (trap_en[s] && !(s == w && !m_pv[s])) begin
          m_pv[s] = 1'b1;
          m_ptid[s] = trap_thread_id[s*TW +: TW];
          m_preason[s] = trap_reason[s*RW +: RW];
        end
      end
    end
    exp_q.push_back({m_out_en, m_out_tid, m_out_reason, m_drop});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val("trap_en_out", 64'(rollback_trap_en), 64'(e[EXP_W-1]));
    check_val("trap_tid_out", 64'(rollback_thread_id), 64'(e[EXP_W-2 -: TW]));
    check_val("trap_reason_out", 64'(rollback_trap_reason), 64'(e[NS +: RW]));
    check_val("trap_drop", 64'(trap_drop), 64'(e[NS-1:0]));
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_trap_en", 64'(rollback_trap_en), 64'd0);
    check_val("rst_trap_tid", 64'(rollback_thread_id), 64'd0);
    check_val("rst_trap_reason", 64'(rollback_trap_reason), 64'd0);
    check_val("rst_drop", 64'(trap_drop), 64'd0);
    check_val("rst_bitmap_t0", rollback_clear_bitmap[SB-1:0], 64'd0);
    reset = 1'b0;

    // issue ages out after FLUSH_DEPTH cycles
    is_instruction_valid = 1'b1; is_thread_id = 3'd2; is_destination_mask = 64'h10;
    #1 check_val("age_c0", 64'(rollback_clear_bitmap[2*SB + 4]), 64'd1);
    step();
    clear_inputs();
    for (int c = 1; c <= 4; c++) begin
      #1 check_val($sformatf("age_c%0d", c), 64'(rollback_clear_bitmap[2*SB + 4]), (c < 4) ? 64'd1 : 64'd0);
      step();
    end

    // branch flush on thread 1 only
    is_instruction_valid = 1'b1; is_thread_id = 3'd1; is_destination_mask = 64'h3;
    step();
    clear_inputs();
    step();
    bc_rollback_valid = 1'b1; bc_rollback_thread_id = 3'd1; bc_scoreboard = 64'h1;
    #1 check_val("flush_t1", rollback_clear_bitmap[1*SB +: SB], 64'h2);
    check_val("flush_t0", rollback_clear_bitmap[0 +: SB], 64'h0);
    step();
    clear_inputs();
    repeat (4) step();

    // branch beats trap on the same thread; trap still reported
    bc_rollback_enable = 1'b1; bc_rollback_thread_id = 3'd3; bc_rollback_pc = 32'h400;
    set_req(0, 3'd3, 32'h800, REASON_LDST);
    #1 check_val("bc_over_trap_pc", 64'(rollback_pc_value[3*AW +: AW]), 64'h400);
    step();
    check_val("bc_trap_reported", 64'({rollback_trap_en, rollback_thread_id}), 64'({1'b1, 3'd3}));
    clear_inputs();
    step();

    // two simultaneous traps are serialised
    set_req(0, 3'd1, 32'h100, REASON_LDST);
    set_req(1, 3'd5, 32'h200, REASON_SPM);
    step();
    check_val("dual_first", 64'({rollback_trap_en, rollback_thread_id, rollback_trap_reason}),
              64'({1'b1, 3'd1, REASON_LDST}));
    clear_inputs();
    step();
    check_val("dual_second", 64'({rollback_trap_en, rollback_thread_id, rollback_trap_reason}),
              64'({1'b1, 3'd5, REASON_SPM}));
    step();

    // overflow: third source-1 request is dropped
    set_req(1, 3'd2, 32'h300, 32'h11);
    step();
    set_req(0, 3'd4, 32'h310, 32'h20);
    set_req(1, 3'd2, 32'h320, 32'h12);
    step();
    set_req(0, 3'd4, 32'h330, 32'h21);
    set_req(1, 3'd2, 32'h340, 32'h13);
    step();
    clear_inputs();
    repeat (3) step();
    check_val("drop_sticky", 64'(trap_drop), 64'h2);

    // traps ignored and state held while disabled
    enable = 1'b0;
    set_req(0, 3'd6, 32'h500, 32'h33);
    is_instruction_valid = 1'b1; is_thread_id = 3'd6; is_destination_mask = 64'hF0;
    repeat (2) step();
    clear_inputs();
    repeat (2) step();

    // reset mid-operation discards pending traps
    set_req(0, 3'd1, 32'h600, 32'h41);
    set_req(1, 3'd2, 32'h610, 32'h42);
    is_instruction_valid = 1'b1; is_thread_id = 3'd0; is_destination_mask = 64'hFF;
    step();
    clear_inputs();
    reset = 1'b1;
    #2;
    check_val("midrst_trap_en", 64'(rollback_trap_en), 64'd0);
    check_val("midrst_drop", 64'(trap_drop), 64'd0);
    check_val("midrst_bitmap_t0", rollback_clear_bitmap[0 +: SB], 64'd0);
    reset = 1'b0;
    model_reset();
    repeat (3) step();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      is_instruction_valid = ($urandom_range(0, 1) == 1);
      is_thread_id = TW'($urandom_range(0, NT - 1));
      is_destination_mask = 64'(1) << $urandom_range(0, SB - 1);
      bc_rollback_enable = ($urandom_range(0, 7) == 0);
      bc_rollback_valid = ($urandom_range(0, 3) == 0);
      bc_rollback_pc = $urandom;
      bc_rollback_thread_id = TW'($urandom_range(0, NT - 1));
      bc_scoreboard = {$urandom, $urandom};
      for (int s = 0; s < NS; s++) begin
        req[s].valid = ($urandom_range(0, 2) == 0);
        req[s].tid = TW'($urandom_range(0, NT - 1));
        req[s].pc = $urandom;
        req[s].reason = $urandom;
      end
      drive_reqs();
      step();
    end
    clear_inputs();
    repeat (2) step();

`ifdef ROLLBACK_PERF_CNT_EN
    // counter saturation on thread 0
    reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    bc_rollback_enable = 1'b1; bc_rollback_thread_id = 3'd0; bc_rollback_pc = 32'h40;
    repeat (65540) @(posedge clk);
    #1 check_val("cnt_saturate", 64'(rollback_count[15:0]), 64'hFFFF);
    check_val("cnt_other", 64'(rollback_count[31:16]), 64'h0);
    clear_inputs();
`endif

    if (exp_q.size() != 0) check_val("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
